pix_stream_aligner: RTL
=======================

PIX_STREAM_ALIGNER -- requirements
Module: pix_stream_aligner

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning pixel-to-output latency in O_PCLK cycles, legal range 2..16.
REQ-002 SHALL have parameter HACT, default 640, meaning expected active pixels per line.
REQ-003 SHALL have parameter VACT, default 480, meaning expected active lines per frame.
REQ-004 SHALL have ports:
- O_PCLK  input  1  pixel clock; all logic on its rising edge
- I_RST  input  1  synchronous, active-high reset
- I_PIX_DATA  input  24  RGB pixel {R[23:16],G[15:8],B[7:0]}
- I_VSYNC, I_HSYNC, I_DE  input  1 each  incoming video timing
- I_MODE  input  2  0 pass, 1 gray, 2 threshold, 3 blank
- I_THRESH  input  8  threshold for mode 2
- O_PIX_DATA  output  24  processed pixel
- O_VSYNC, O_HSYNC, O_DE  output  1 each  timing aligned to O_PIX_DATA
- O_COL  output  $clog2(HACT)  column of current O_PIX_DATA
- O_ROW  output  $clog2(VACT)  row of current O_PIX_DATA
- O_LOCKED  output  1  lock FSM in LOCKED
- O_LINE_ERR  output  1  one-cycle pulse on geometry error
- O_ERR_CNT  output  16  error count (see Configuration)

Function
REQ-005 Luma SHALL be Y = (77*R + 150*G + 29*B) >> 8, 16-bit unsigned intermediate, no rounding; Y=FF for white input.
REQ-006 Output data SHALL be: mode 0 input RGB; mode 1 {Y,Y,Y}; mode 2 FFFFFF if Y >= I_THRESH else 000000; mode 3 000000.
REQ-007 I_MODE and I_THRESH SHALL be sampled with the pixel in input stage 0 and travel with it; mode changes never split a pixel.
REQ-008 O_VSYNC, O_HSYNC and ungated DE SHALL be inputs delayed exactly LAT cycles, identical for every mode.
REQ-009 O_PIX_DATA SHALL be 000000 whenever O_DE=0.
REQ-010 Lock FSM states: UNLOCKED, WAIT_DE, LOCKED, evaluated on undelayed inputs.
REQ-011 UNLOCKED -> WAIT_DE on I_VSYNC rising edge; WAIT_DE -> LOCKED on first I_DE rising edge; LOCKED -> UNLOCKED on geometry error.
REQ-012 In LOCKED, a line SHALL be the run of I_DE=1 cycles; col counts 0..HACT-1, clears on I_DE falling edge.
REQ-013 Row SHALL increment on each I_DE falling edge, clear on I_VSYNC rising edge.
REQ-014 Geometry error: I_DE falls with col count != HACT, or I_DE rises with row == VACT; SHALL pulse O_LINE_ERR one cycle (LAT-aligned) and drop to UNLOCKED.
REQ-015 I_VSYNC rising edge while LOCKED SHALL restart the frame (row 0) without error.
REQ-016 O_DE SHALL be delayed I_DE AND delayed (state==LOCKED); O_COL/O_ROW delayed LAT, held at 0 when O_DE=0.
REQ-017 O_LOCKED SHALL reflect the FSM state delayed LAT cycles.
REQ-018 Simultaneous I_VSYNC rise and I_DE fall SHALL evaluate the line check before the row clear.

Reset
REQ-019 On I_RST=1 at an O_PCLK edge: FSM=UNLOCKED, counters 0, all delay stages 0.
REQ-020 During and one cycle after reset all outputs SHALL be 0; reset mid-frame requires a fresh I_VSYNC rise to relock.

Configuration
REQ-021 Macro PIX_STREAM_ALIGNER_ERR_CNT_EN defined: O_ERR_CNT increments on each O_LINE_ERR pulse, saturates at FFFF, cleared only by I_RST.
REQ-022 Macro undefined: O_ERR_CNT SHALL be constant 0 and no counter logic synthesised; all other behaviour identical.

Verification
REQ-023 Reset, then 640x480 frame of FF0000, mode 1, LAT=3 -> O_DE first high 3 cycles after first I_DE of locked frame, O_PIX_DATA=4C4C4C, O_LOCKED=1.
REQ-024 Mode 2, I_THRESH=80, pixels 808080 then 7F7F7F -> FFFFFF then 000000.
REQ-025 Locked, line with 639 DE cycles -> one O_LINE_ERR pulse, O_LOCKED falls, O_DE stays 0 until next I_VSYNC rise plus first DE.
REQ-026 Syncs toggled in every mode -> O_VSYNC/O_HSYNC equal inputs shifted exactly LAT cycles; last pixel of frame shows O_COL=639, O_ROW=479.
REQ-027 With PIX_STREAM_ALIGNER_ERR_CNT_EN: 3 bad lines -> O_ERR_CNT=3; without macro -> O_ERR_CNT=0.
REQ-028 I_RST asserted mid-line -> next cycle all outputs 0, O_LOCKED=0 until relock.

Source files
------------

// File: rtl/pix_stream_aligner.sv
// Pixel pipeline (pass / gray / threshold / blank) whose timing outputs are aligned LAT cycles behind
// the inputs, plus a frame-geometry lock FSM. Define PIX_STREAM_ALIGNER_ERR_CNT_EN to build the error counter.
module pix_stream_aligner #(
    parameter int LAT  = 3,
    parameter int HACT = 640,
    parameter int VACT = 480
) (
    input  logic                    O_PCLK,
    input  logic                    I_RST,
    input  logic [23:0]             I_PIX_DATA,
    input  logic                    I_VSYNC,
    input  logic                    I_HSYNC,
    input  logic                    I_DE,
    input  logic [1:0]              I_MODE,
    input  logic [7:0]              I_THRESH,
    output logic [23:0]             O_PIX_DATA,
    output logic                    O_VSYNC,
    output logic                    O_HSYNC,
    output logic                    O_DE,
    output logic [$clog2(HACT)-1:0] O_COL,
    output logic [$clog2(VACT)-1:0] O_ROW,
    output logic                    O_LOCKED,
    output logic                    O_LINE_ERR,
    output logic [15:0]             O_ERR_CNT
);

    localparam int CW  = $clog2(HACT);
    localparam int RW  = $clog2(VACT);
    localparam int CCW = $clog2(HACT + 2);
    localparam int RCW = $clog2(VACT + 1);

    typedef enum logic [1:0] {UNLOCKED, WAIT_DE, LOCKED} state_t;

    typedef struct packed {
        logic [23:0]   pix;
        logic          vs;
        logic          hs;
        logic          de;
        logic          lock;
        logic          err;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } stage_t;

    function automatic logic [7:0] luma(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'd77 * 16'(rgb[23:16]) + 16'd150 * 16'(rgb[15:8]) + 16'd29 * 16'(rgb[7:0]);
        return acc[15:8];
    endfunction

    function automatic logic [23:0] shade(input logic [1:0] mode, input logic [7:0] thresh,
                                          input logic [23:0] rgb);
        logic [7:0]  y;
        logic [23:0] res;
        y = luma(rgb);
        case (mode)
            2'd0:    res = rgb;
            2'd1:    res = {y, y, y};
            2'd2:    res = (y >= thresh) ? 24'hFFFFFF : 24'h000000;
            default: res = 24'h000000;
        endcase
        return res;
    endfunction

    state_t         state;
    logic           vs_q;
    logic           de_q;
    logic [CCW-1:0] col_cnt;
    logic [RCW-1:0] row_cnt;
    logic           vs_rise;
    logic           de_rise;
    logic           de_fall;
    logic           line_err;
    logic           lock_cur;
    logic [RCW-1:0] row_cur;

    assign vs_rise = I_VSYNC & ~vs_q;
    assign de_rise = I_DE & ~de_q;
    assign de_fall = ~I_DE & de_q;
    // A frame restart coinciding with a line start puts that line at row 0.
    assign row_cur = vs_rise ? '0 : row_cnt;

    always_comb begin
        line_err = 1'b0;
        if (state == LOCKED) begin
            if (de_fall && (col_cnt != CCW'(HACT)))
                line_err = 1'b1;
            if (de_rise && (row_cur == RCW'(VACT)))
                line_err = 1'b1;
        end
    end

    // Lock status that applies to the pixel presented this cycle (the state being entered).
    assign lock_cur = ((state == LOCKED) && !line_err) || ((state == WAIT_DE) && de_rise);

    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            state   <= UNLOCKED;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            vs_q <= I_VSYNC;
            de_q <= I_DE;
            case (state)
                UNLOCKED: if (vs_rise) state <= WAIT_DE;
                WAIT_DE:  if (de_rise) state <= LOCKED;
                LOCKED:   if (line_err) state <= vs_rise ? WAIT_DE : UNLOCKED;
                default:  state <= UNLOCKED;
            endcase
            if (!lock_cur) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else begin
                if (!I_DE)
                    col_cnt <= '0;
                else if (col_cnt != CCW'(HACT + 1))
                    col_cnt <= col_cnt + CCW'(1);
                // Line end is counted first; a simultaneous frame restart then wins.
                if (vs_rise)
                    row_cnt <= '0;
                else if (de_fall && (row_cnt != RCW'(VACT)))
                    row_cnt <= row_cnt + RCW'(1);
            end
        end
    end

    // Stage 0: capture pixel, per-pixel controls and geometry together
    logic [23:0]   pix_p0;
    logic [1:0]    mode_p0;
    logic [7:0]    thresh_p0;
    logic          vs_p0;
    logic          hs_p0;
    logic          de_p0;
    logic          lock_p0;
    logic          err_p0;
    logic [CW-1:0] col_p0;
    logic [RW-1:0] row_p0;

    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            pix_p0    <= '0;
            mode_p0   <= '0;
            thresh_p0 <= '0;
            vs_p0     <= 1'b0;
            hs_p0     <= 1'b0;
            de_p0     <= 1'b0;
            lock_p0   <= 1'b0;
            err_p0    <= 1'b0;
            col_p0    <= '0;
            row_p0    <= '0;
        end else begin
            pix_p0    <= I_PIX_DATA;
            mode_p0   <= I_MODE;
            thresh_p0 <= I_THRESH;
            vs_p0     <= I_VSYNC;
            hs_p0     <= I_HSYNC;
            de_p0     <= I_DE;
            lock_p0   <= lock_cur;
            err_p0    <= line_err;
            col_p0    <= col_cnt[CW-1:0];
            row_p0    <= row_cur[RW-1:0];
        end
    end

    // Stage 1: pixel processing and DE gating
    logic   de_gated;
    stage_t stage1;

    assign de_gated = de_p0 & lock_p0;

    always_comb begin
        stage1      = '0;
        stage1.vs   = vs_p0;
        stage1.hs   = hs_p0;
        stage1.de   = de_gated;
        stage1.lock = lock_p0;
        stage1.err  = err_p0;
        if (de_gated) begin
            stage1.pix = shade(mode_p0, thresh_p0, pix_p0);
            stage1.col = col_p0;
            stage1.row = row_p0;
        end
    end

    // Stages 1..LAT-1: result register followed by the alignment delay line
    stage_t stg_p [1:LAT-1];

    always_ff @(posedge O_PCLK) begin
        if (I_RST) begin
            for (int i = 1; i < LAT; i++)
                stg_p[i] <= '0;
        end else begin
            stg_p[1] <= stage1;
            for (int i = 2; i < LAT; i++)
                stg_p[i] <= stg_p[i-1];
        end
    end

    stage_t out_q;
    assign out_q = I_RST ? '0 : stg_p[LAT-1];

    assign O_PIX_DATA = out_q.pix;
    assign O_VSYNC    = out_q.vs;
    assign O_HSYNC    = out_q.hs;
    assign O_DE       = out_q.de;
    assign O_COL      = out_q.col;
    assign O_ROW      = out_q.row;
    assign O_LOCKED   = out_q.lock;
    assign O_LINE_ERR = out_q.err;

`ifdef PIX_STREAM_ALIGNER_ERR_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] err_cnt;

    always_ff @(posedge O_PCLK) begin
        if (I_RST)
            err_cnt <= '0;
        else if (stg_p[LAT-1].err)
            err_cnt <= sat_inc(err_cnt);
    end

    assign O_ERR_CNT = I_RST ? 16'h0000 : err_cnt;
`else
    assign O_ERR_CNT = 16'h0000;
`endif

endmodule
